// File: rtl/fifo_drain_pkg.sv
// Shared constants and state encoding for the FIFO pop-side drain logic.
package fifo_drain_pkg;

  localparam logic [3:0] FLAG_EMPTY = 4'h0;
  localparam logic [3:0] FLAG_ONE   = 4'h1;

  localparam int SETTLE_CYCLES = 2;
  localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    SETTLE
  } drain_state_t;

endpackage

// File: rtl/skid_fifo.sv
// Small shift-register FIFO; entry 0 is always the head so rd_data and valid
// come straight from flops.
module skid_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] mem_n [DEPTH];
  logic [OCC_W-1:0]  occ_n;

  // A read shifts everything down one slot; a write then lands just past the
  // surviving entries, so a simultaneous read and write keeps occ unchanged.
  always_comb begin
    mem_n = mem;
    occ_n = occ;
    if (rd && (occ != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_n[i] = mem[i + 1];
      end
      occ_n = occ - OCC_W'(1);
    end
    if (wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (OCC_W'(i) == occ_n) begin
          mem_n[i] = wr_data;
        end
      end
      occ_n = occ_n + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '{default: '0};
      occ   <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      occ   <= '0;
      valid <= 1'b0;
    end else begin
      mem   <= mem_n;
      occ   <= occ_n;
      valid <= (occ_n != '0);
    end
  end

  assign rd_data = mem[0];

endmodule

// File: rtl/fifo_pop_drain.sv
// Pop-side consumer for a sync-mode FIFO half: issues POP from POP_FLAG,
// captures DOUT into a skid buffer and streams it out as valid/ready.
module fifo_pop_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [3:0]        POP_FLAG,
  input  logic [DATA_W-1:0] DOUT,
  output logic              POP,
  output logic              Fifo_Pop_Flush,
  input  logic              Flush_Req,
  output logic [DATA_W-1:0] M_Data,
  output logic              M_Valid,
  input  logic              M_Ready,
  output logic [CNT_W-1:0]  Pop_Count,
  output logic              Busy
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  drain_state_t        state, state_next;
  logic [SETTLE_W-1:0] settle_cnt, settle_next;
  logic                pop_q, inflight_q, flush_q, busy_q;
  logic                pop_next, deq, flush_go, safe_nonempty, has_room;
  logic                skid_wr, skid_valid;
  logic [OCC_W-1:0]    occ;
  logic [DATA_W-1:0]   skid_head;
  logic [CNT_W-1:0]    pop_count;

  assign deq      = skid_valid & M_Ready;
  assign flush_go = (state == RUN) & Flush_Req;

  // The flag does not yet reflect the pop currently on the POP line, so a
  // flag of one word plus an active POP means the FIFO is about to be empty.
  assign safe_nonempty = (POP_FLAG != FLAG_EMPTY) &&
                         !((POP_FLAG == FLAG_ONE) && pop_q);

  // Reserve a skid slot for every word already committed (buffered, arriving
  // on DOUT now, or popped this cycle) before committing another.
  assign has_room = (SUM_W'(occ) + SUM_W'(inflight_q) + SUM_W'(pop_q))
                    < (SUM_W'(SKID_DEPTH) + SUM_W'(deq));

  assign pop_next = (state == RUN) && !Flush_Req && has_room && safe_nonempty;
  assign skid_wr  = inflight_q && (state == RUN);

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    case (state)
      RUN: begin
        if (Flush_Req) state_next = FLUSH;
      end
      FLUSH: begin
        state_next  = SETTLE;
        settle_next = '0;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_next = RUN;
        end else begin
          settle_next = settle_cnt + SETTLE_W'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= RUN;
      settle_cnt <= '0;
      pop_q      <= 1'b0;
      inflight_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      pop_count  <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      pop_q      <= pop_next;
      inflight_q <= pop_q;
      flush_q    <= (state_next == FLUSH);
      busy_q     <= (state_next != RUN);
      pop_count  <= pop_count + CNT_W'(deq);
    end
  end

  skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (flush_go),
    .wr      (skid_wr),
    .wr_data (DOUT),
    .rd      (deq),
    .rd_data (skid_head),
    .valid   (skid_valid),
    .occ     (occ)
  );

  assign POP            = pop_q;
  assign Fifo_Pop_Flush = flush_q;
  assign M_Valid        = skid_valid;
  assign M_Data         = skid_head;
  assign Pop_Count      = pop_count;
  assign Busy           = busy_q;

  a_skid_bound: assert property (@(posedge Clk) disable iff (Rst)
    occ <= OCC_W'(SKID_DEPTH));
  a_no_pop_empty: assert property (@(posedge Clk) disable iff (Rst)
    !(pop_next && (POP_FLAG == FLAG_EMPTY)));

endmodule

// File: tb/tb_fifo_pop_drain.sv
// Directed bench for fifo_pop_drain with a behavioural sync FIFO on the pop side.
module tb_fifo_pop_drain;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  POP_FLAG;
  logic [15:0] DOUT;
  logic        POP;
  logic        Fifo_Pop_Flush;
  logic        Flush_Req;
  logic [15:0] M_Data;
  logic        M_Valid;
  logic        M_Ready;
  logic [15:0] Pop_Count;
  logic        Busy;

  int checks = 0;
  int errors = 0;
  int pop_seen = 0;
  int pushed = 0;
  int popped = 0;
  logic [15:0] fifo_mem [64];
  logic [15:0] dout_q = '0;
  logic [15:0] exp_q [$];
  logic        found;

  always #5 Clk = ~Clk;

  fifo_pop_drain #(
    .DATA_W     (16),
    .SKID_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .POP_FLAG       (POP_FLAG),
    .DOUT           (DOUT),
    .POP            (POP),
    .Fifo_Pop_Flush (Fifo_Pop_Flush),
    .Flush_Req      (Flush_Req),
    .M_Data         (M_Data),
    .M_Valid        (M_Valid),
    .M_Ready        (M_Ready),
    .Pop_Count      (Pop_Count),
    .Busy           (Busy)
  );

  // FIFO model: word count drops at the edge that samples POP, so the flag
  // lags the POP line by one cycle; DOUT is valid the cycle after POP.
  always_comb begin
    int c;
    c = pushed - popped;
    if (c <= 0)      POP_FLAG = 4'h0;
    else if (c > 15) POP_FLAG = 4'hF;
    else             POP_FLAG = 4'(c);
  end

  assign DOUT = dout_q;

  always @(posedge Clk) begin
    if (Fifo_Pop_Flush) begin
      popped <= pushed;
    end else if (POP && (pushed - popped) > 0) begin
      dout_q <= fifo_mem[popped % 64];
      popped <= popped + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushWord(input logic [15:0] w);
    fifo_mem[pushed % 64] = w;
    pushed++;
    exp_q.push_back(w);
  endtask

  task automatic monitorCycle();
    if (POP === 1'b1) begin
      pop_seen++;
      checkOutput("pop_not_on_empty", 32'((pushed - popped) > 0), 32'd1);
    end
    if (M_Valid === 1'b1 && M_Ready === 1'b1) begin
      checkOutput("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) checkOutput("m_data_order", 32'(M_Data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic flush);
    M_Ready   = ready;
    Flush_Req = flush;
    monitorCycle();
    @(posedge Clk);
    #1;
    Flush_Req = 1'b0;
  endtask

  initial begin
    Rst       = 1'b1;
    M_Ready   = 1'b0;
    Flush_Req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_pop",   32'(POP), 32'd0);
    checkOutput("rst_flush", 32'(Fifo_Pop_Flush), 32'd0);
    checkOutput("rst_valid", 32'(M_Valid), 32'd0);
    checkOutput("rst_data",  32'(M_Data), 32'd0);
    checkOutput("rst_count", 32'(Pop_Count), 32'd0);
    checkOutput("rst_busy",  32'(Busy), 32'd0);
    Rst = 1'b0;

    // Empty FIFO: nothing happens
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("t1_pop",   32'(POP), 32'd0);
      checkOutput("t1_valid", 32'(M_Valid), 32'd0);
      checkOutput("t1_count", 32'(Pop_Count), 32'd0);
    end

    // Eight words streamed with M_Ready held high
    for (int i = 1; i <= 8; i++) pushWord(16'(i));
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t2_count", 32'(Pop_Count), 32'd8);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_idle_valid", 32'(M_Valid), 32'd0);
    checkOutput("t2_fifo_empty", 32'(pushed - popped), 32'd0);

    // Backpressure: only two pops fit while stalled, head held stable
    pop_seen = 0;
    for (int i = 1; i <= 6; i++) pushWord(16'(i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (i == 4 || i == 9) begin
        checkOutput("t3_stall_valid", 32'(M_Valid), 32'd1);
        checkOutput("t3_stall_data", 32'(M_Data), 32'h0001);
      end
    end
    checkOutput("t3_stall_pops", 32'(pop_seen), 32'd2);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t3_count", 32'(Pop_Count), 32'd14);

    // Single word with POP_FLAG=1
    pop_seen = 0;
    pushWord(16'hA5A5);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t4_single_pop", 32'(pop_seen), 32'd1);
    checkOutput("t4_count", 32'(Pop_Count), 32'd15);

    // Flush while a word is buffered, being dequeued, and a pop is on the line
    for (int i = 1; i <= 10; i++) pushWord(16'h0100 + 16'(i));
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (POP === 1'b1 && M_Valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b0);
    end
    checkOutput("t5_setup", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1);
    exp_q.delete();
    checkOutput("t5_flush_pulse", 32'(Fifo_Pop_Flush), 32'd1);
    checkOutput("t5_flush_valid", 32'(M_Valid), 32'd0);
    checkOutput("t5_flush_busy", 32'(Busy), 32'd1);
    checkOutput("t5_flush_pop", 32'(POP), 32'd0);
    checkOutput("t5_flush_count", 32'(Pop_Count), 32'd17);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_settle0_flush", 32'(Fifo_Pop_Flush), 32'd0);
    checkOutput("t5_settle0_busy", 32'(Busy), 32'd1);
    checkOutput("t5_settle0_valid", 32'(M_Valid), 32'd0);
    checkOutput("t5_settle0_pop", 32'(POP), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_settle1_busy", 32'(Busy), 32'd1);
    checkOutput("t5_settle1_flush", 32'(Fifo_Pop_Flush), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_run_busy", 32'(Busy), 32'd0);
    checkOutput("t5_run_flush", 32'(Fifo_Pop_Flush), 32'd0);
    checkOutput("t5_run_pop", 32'(POP), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_discard_valid", 32'(M_Valid), 32'd0);
    checkOutput("t5_final_count", 32'(Pop_Count), 32'd17);

    // Reset mid-stream with a full skid buffer
    for (int i = 1; i <= 6; i++) pushWord(16'h0200 + 16'(i));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("t6_pre_valid", 32'(M_Valid), 32'd1);
    checkOutput("t6_pre_pop", 32'(POP), 32'd0);
    Rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    Rst = 1'b0;
    exp_q.delete();
    checkOutput("t6_rst_valid", 32'(M_Valid), 32'd0);
    checkOutput("t6_rst_pop", 32'(POP), 32'd0);
    checkOutput("t6_rst_count", 32'(Pop_Count), 32'd0);
    checkOutput("t6_rst_flush", 32'(Fifo_Pop_Flush), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_post_flush", 32'(Fifo_Pop_Flush), 32'd0);
    checkOutput("t6_post_busy", 32'(Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
